// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronizes a bouncing button and accepts a level change after SAMPLES consecutive agreeing ticks.
module debounce_fsm #(
  parameter int SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic sample_tick,
  output logic timer_en,
  output logic btn_clean,
  output logic btn_press,
  output logic btn_release
);
  typedef enum logic [1:0] {IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW} state_t;
  localparam logic [3:0] LAST = 4'(SAMPLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic sync0, btn_sync, lvl, chk, diff, hit;
  assign timer_en = chk;
  always_comb begin
    lvl = state == IDLE_HIGH || state == CHECK_LOW;
    chk = state == CHECK_HIGH || state == CHECK_LOW;
    diff = btn_sync != lvl;
    hit = chk && diff && sample_tick && cnt == LAST;
    state_nx = state;
    cnt_nx = cnt;
    if (!diff) begin
      state_nx = lvl ? IDLE_HIGH : IDLE_LOW;
      cnt_nx = '0;
    end else if (!chk) begin
      state_nx = lvl ? CHECK_LOW : CHECK_HIGH;
      cnt_nx = '0;
    end else if (sample_tick) begin
      state_nx = hit ? (lvl ? IDLE_LOW : IDLE_HIGH) : state;
      cnt_nx = hit ? '0 : cnt + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      btn_sync <= 1'b0;
      state <= IDLE_LOW;
      cnt <= '0;
      btn_clean <= 1'b0;
      btn_press <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync0 <= btn_raw;
      btn_sync <= sync0;
      state <= state_nx;
      cnt <= cnt_nx;
      btn_clean <= state_nx == IDLE_HIGH || state_nx == CHECK_LOW;
      btn_press <= state == CHECK_HIGH && state_nx == IDLE_HIGH;
      btn_release <= state == CHECK_LOW && state_nx == IDLE_LOW;
    end
  end
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: vector table, corner sequences, random run against a run-length reference model, and a timer-driven press.
module tb_debounce_fsm;
  localparam int SAMPLES = 3;
  localparam int P = 4000;
  logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, sample_tick = 1'b0;
  logic timer_en, btn_clean, btn_press, btn_release;
  int checks = 0, failures = 0;
  logic m_s1 = 0, m_s2 = 0, m_clean = 0, m_te = 0, m_press = 0, m_rel = 0;
  int run = 0, n = 0;
  always #5 clk = ~clk;
  debounce_fsm #(.SAMPLES(SAMPLES)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sample_tick(sample_tick),
    .timer_en(timer_en), .btn_clean(btn_clean), .btn_press(btn_press), .btn_release(btn_release)
  );
  typedef struct {
    logic r, raw, tk;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl[23];
  task automatic chk(input string nm, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, a, e);
    end
  endtask
  // Model: n counts ticks seen while the synced level has disagreed with the
  // clean level for more than one cycle; the first disagreeing cycle ignores ticks.
  task automatic model(input logic r, input logic raw, input logic tk);
    logic d;
    m_press = 0;
    m_rel = 0;
    if (r) begin
      {m_s1, m_s2, m_clean, m_te} = '0;
      run = 0;
      n = 0;
      return;
    end
    d = m_s2 != m_clean;
    if (!d) begin
      run = 0;
      n = 0;
    end else begin
      if (run > 0 && tk) n++;
      run++;
    end
    if (n == SAMPLES) begin
      m_clean = !m_clean;
      m_press = m_clean;
      m_rel = !m_clean;
      run = 0;
      n = 0;
    end
    m_te = run > 0;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask
  task automatic cyc(input logic r, input logic raw, input logic tk);
    rst = r;
    btn_raw = raw;
    sample_tick = tk;
    @(posedge clk);
    model(r, raw, tk);
    @(negedge clk);
    chk("model_timer_en", timer_en, m_te);
    chk("model_btn_clean", btn_clean, m_clean);
    chk("model_btn_press", btn_press, m_press);
    chk("model_btn_release", btn_release, m_rel);
    chk("press_release_exclusive", btn_press & btn_release, 1'b0);
  endtask
  initial begin
    int cnt, t0, seen;
    logic te, tk, raw;
    tbl = '{
      '{1,1,0,4'b0000}, '{1,1,1,4'b0000}, '{1,1,0,4'b0000}, '{0,1,0,4'b0000},
      '{0,1,0,4'b0000}, '{0,1,1,4'b1000}, '{0,1,1,4'b1000}, '{0,1,0,4'b1000},
      '{0,1,1,4'b1000}, '{0,1,1,4'b0110}, '{0,1,0,4'b0100}, '{0,0,0,4'b0100},
      '{0,0,0,4'b0100}, '{0,0,1,4'b1100}, '{0,0,1,4'b1100}, '{0,1,0,4'b1100},
      '{0,0,1,4'b1100}, '{0,0,1,4'b0100}, '{0,0,1,4'b1100}, '{0,0,1,4'b1100},
      '{0,0,1,4'b1100}, '{0,0,1,4'b0001}, '{0,0,0,4'b0000}
    };
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].raw, tbl[i].tk);
      chk($sformatf("vec%0d", i), {timer_en, btn_clean, btn_press, btn_release} == tbl[i].exp, 1'b1);
    end
    // Abort with a simultaneous tick at count 2, then a fresh full qualification.
    repeat (2) cyc(1, 1, 0);
    repeat (3) cyc(0, 1, 0);
    chk("check_high_entered", timer_en, 1'b1);
    repeat (2) cyc(0, 1, 1);
    repeat (2) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("abort_timer_en", timer_en, 1'b0);
    chk("abort_no_press", btn_press | btn_clean, 1'b0);
    repeat (3) cyc(0, 1, 0);
    repeat (2) cyc(0, 1, 1);
    chk("count_cleared", btn_clean, 1'b0);
    cyc(0, 1, 1);
    chk("fresh_press", btn_press & btn_clean, 1'b1);
    // Reset while clean is high and while checking: no pulses, requalification needed.
    cyc(1, 1, 0);
    chk("rst_idle_high_clean", btn_clean | btn_release | btn_press, 1'b0);
    repeat (3) cyc(0, 1, 0);
    repeat (2) cyc(0, 1, 1);
    cyc(1, 1, 1);
    chk("rst_in_check", btn_clean | btn_press | timer_en, 1'b0);
    repeat (3) cyc(0, 1, 0);
    repeat (2) cyc(0, 1, 1);
    chk("requalify_pending", btn_clean, 1'b0);
    cyc(0, 1, 1);
    chk("requalify_done", btn_press, 1'b1);
    // Random run.
    raw = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) raw = ~raw;
      cyc($urandom_range(299) == 0, raw, $urandom_range(3) == 0);
    end
    // Integrated run with a behavioural tick timer that holds at zero while disabled.
    repeat (2) cyc(1, 0, 0);
    cnt = 0;
    t0 = -1;
    seen = 0;
    for (int i = 0; i < 4 * P + 100 && !seen; i++) begin
      te = timer_en;
      if (te && t0 < 0) t0 = i;
      if (btn_press) seen = i;
      tk = te && cnt == P - 1;
      cyc(0, 1, tk);
      cnt = te ? (cnt == P - 1 ? 0 : cnt + 1) : 0;
    end
    checks++;
    if (seen == 0 || t0 < 0 || seen - t0 < 3 * P - 3 || seen - t0 > 3 * P + 3) begin
      failures++;
      $display("FAIL integrated_latency: got %0d cycles expected %0d", seen - t0, 3 * P);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
